// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcode constants, hazard FSM state type and register-use helpers
//
// Purpose: definitions shared by the RV32I pipeline hazard controller.
// Ports:   none (package).
//   LOAD..AUIPC     7-bit major opcodes
//   NOP_IW          canonical NOP (addi x0,x0,0) used for bubbles and flushes
//   hz_state_t      sequencing FSM states
//   uses_rs1/rs2    1 when the opcode reads that source register
package rv32i_pkg;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [31:0] NOP_IW = 32'h00000013;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } hz_state_t;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      case (opcode)
         OP, OP_IMM, LOAD, STORE, BRANCH, JALR: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      case (opcode)
         OP, STORE, BRANCH: return 1'b1;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_hazard_detect.sv
// rtl/rv32i_hazard_detect.sv - combinational load-use hazard detector
//
// Purpose: flags a load in EX whose destination is read by the instruction in ID.
// Ports:
//   id_iw_in      in  32  instruction word in ID
//   ex_iw_in      in  32  instruction word in EX
//   ex_wb_en_in   in  1   EX writeback enable
//   ex_wb_reg_in  in  5   EX writeback register
//   lu_out        out 1   load-use hazard (before priority suppression)
module rv32i_hazard_detect
   import rv32i_pkg::*;
(
   input  logic [31:0] id_iw_in,
   input  logic [31:0] ex_iw_in,
   input  logic        ex_wb_en_in,
   input  logic [4:0]  ex_wb_reg_in,
   output logic        lu_out
);

   logic       ex_is_load;
   logic [6:0] id_opcode;
   logic       rs1_hit;
   logic       rs2_hit;

   assign ex_is_load = (ex_iw_in[6:0] == LOAD) && ex_wb_en_in && (ex_wb_reg_in != 5'd0);
   assign id_opcode  = id_iw_in[6:0];

   // Only source fields the ID opcode actually reads count; immediates that
   // happen to alias the rs fields must not stall.
   assign rs1_hit = uses_rs1(id_opcode) && (id_iw_in[19:15] == ex_wb_reg_in);
   assign rs2_hit = uses_rs2(id_opcode) && (id_iw_in[24:20] == ex_wb_reg_in);

   assign lu_out = ex_is_load && (rs1_hit || rs2_hit);

   logic unused_iw_bits;
   assign unused_iw_bits = ^{id_iw_in[31:25], id_iw_in[14:7], ex_iw_in[31:7]};

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// rtl/rv32i_hazard_ctrl.sv - RV32I pipeline stall/flush/freeze sequencing controller
//
// Purpose: load-use interlock, redirect flushing, memory-wait freeze and
//          memory-wait timeout watchdog for the 5-stage pipeline.
// Parameter: MEM_TIMEOUT freeze cycles per memory wait before timeout (0 = no watchdog).
// Macro:     HAZARD_PERF_CNT_EN enables the three 32-bit event counters;
//            undefined, the perf ports are tied to 0.
// Ports:
//   clk, reset                     clock, async active-high reset
//   id_iw_in, ex_iw_in             ID / EX instruction words
//   ex_wb_en_in, ex_wb_reg_in      EX writeback tag
//   redirect_in, redirect_target_in taken branch/jump resolved in EX and its target
//   mem_req_in, mem_ready_in       MEM stage access handshake
//   stall_if_out, stall_id_out     hold PC+IF/ID, hold ID/EX inputs
//   bubble_ex_out                  load NOP into EX
//   flush_if_out, flush_id_out     replace IF/ID, ID/EX with NOP
//   freeze_out                     hold every pipeline register
//   pc_sel_out, pc_target_out      PC redirect select and target
//   err_timeout_out                sticky memory timeout
//   perf_stall/flush/freeze_out    event counters
module rv32i_hazard_ctrl
   import rv32i_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] id_iw_in,
   input  logic [31:0] ex_iw_in,
   input  logic        ex_wb_en_in,
   input  logic [4:0]  ex_wb_reg_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_target_in,
   input  logic        mem_req_in,
   input  logic        mem_ready_in,
   output logic        stall_if_out,
   output logic        stall_id_out,
   output logic        bubble_ex_out,
   output logic        flush_if_out,
   output logic        flush_id_out,
   output logic        freeze_out,
   output logic        pc_sel_out,
   output logic [31:0] pc_target_out,
   output logic        err_timeout_out,
   output logic [31:0] perf_stall_out,
   output logic [31:0] perf_flush_out,
   output logic [31:0] perf_freeze_out
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   hz_state_t        state;
   hz_state_t        state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_nxt;
   logic             lu;
   logic             mem_stall;
   logic             timeout_hit;
   logic             freeze;

   rv32i_hazard_detect u_detect (
      .id_iw_in     (id_iw_in),
      .ex_iw_in     (ex_iw_in),
      .ex_wb_en_in  (ex_wb_en_in),
      .ex_wb_reg_in (ex_wb_reg_in),
      .lu_out       (lu)
   );

   assign mem_stall   = mem_req_in && !mem_ready_in;
   // Compare in 32 bits so the +1 cannot wrap inside the narrow counter.
   assign timeout_hit = (MEM_TIMEOUT != 0) &&
                        ((32'(wait_cnt) + 32'd1) == 32'(MEM_TIMEOUT));
   assign freeze      = (state == TIMEOUT) || mem_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // The count restarts whenever a wait ends, so every memory wait gets its
   // own MEM_TIMEOUT budget even when waits are back to back.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         RUN, MEM_WAIT: begin
            if (mem_stall) begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
               state_nxt    = timeout_hit ? TIMEOUT : MEM_WAIT;
            end else begin
               wait_cnt_nxt = '0;
               state_nxt    = RUN;
            end
         end
         TIMEOUT: begin
            state_nxt = TIMEOUT;
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // Priority: reset, freeze/timeout, redirect, load-use. A redirect seen
   // under freeze is dropped here because EX holds it until unfrozen.
   always_comb begin
      stall_if_out    = 1'b0;
      stall_id_out    = 1'b0;
      bubble_ex_out   = 1'b0;
      flush_if_out    = 1'b0;
      flush_id_out    = 1'b0;
      freeze_out      = 1'b0;
      pc_sel_out      = 1'b0;
      pc_target_out   = 32'd0;
      err_timeout_out = 1'b0;
      if (!reset) begin
         pc_target_out   = redirect_target_in;
         err_timeout_out = (state == TIMEOUT);
         if (freeze) begin
            freeze_out = 1'b1;
         end else if (redirect_in) begin
            pc_sel_out   = 1'b1;
            flush_if_out = 1'b1;
            flush_id_out = 1'b1;
         end else if (lu) begin
            stall_if_out  = 1'b1;
            stall_id_out  = 1'b1;
            bubble_ex_out = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;
   logic [31:0] perf_freeze_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_q  <= 32'd0;
         perf_flush_q  <= 32'd0;
         perf_freeze_q <= 32'd0;
      end else begin
         if (stall_if_out) perf_stall_q  <= perf_stall_q + 32'd1;
         if (pc_sel_out)   perf_flush_q  <= perf_flush_q + 32'd1;
         if (freeze_out)   perf_freeze_q <= perf_freeze_q + 32'd1;
      end
   end

   assign perf_stall_out  = perf_stall_q;
   assign perf_flush_out  = perf_flush_q;
   assign perf_freeze_out = perf_freeze_q;
`else
   assign perf_stall_out  = 32'd0;
   assign perf_flush_out  = 32'd0;
   assign perf_freeze_out = 32'd0;
`endif

endmodule
